// File: rtl/debug_step_controller_pkg.sv
// rtl/debug_step_controller_pkg.sv - shared debug command codes and controller state encodings
package debug_step_controller_pkg;

    typedef enum logic [1:0] {
        CMD_HALT    = 2'b00,
        CMD_RUN     = 2'b01,
        CMD_STEP    = 2'b10,
        CMD_RESTART = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_step_controller_if.sv
// rtl/debug_step_controller_if.sv - debug host command handshake and pipeline control bundle
interface debug_step_controller_if;
    import debug_step_controller_pkg::*;

    logic        cmdValid;
    logic [1:0]  cmd;
    logic        cmdReady;
    logic        eopIn;
    logic        debugEnable;
    logic        debugReset;
    logic        halted;
    logic [31:0] cycleCount;
    logic [2:0]  state;

    // Host side: issues commands and forwards the write-back end-of-program flag.
    modport master (
        output cmdValid, cmd, eopIn,
        input  cmdReady, debugEnable, debugReset, halted, cycleCount, state
    );

    // Controller side.
    modport slave (
        input  cmdValid, cmd, eopIn,
        output cmdReady, debugEnable, debugReset, halted, cycleCount, state
    );
endinterface

// File: rtl/debug_step_controller_sat_counter32.sv
// rtl/debug_step_controller_sat_counter32.sv - 32-bit counter that sticks at all-ones instead of wrapping
module sat_counter32
    import debug_step_controller_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    logic [31:0] countQ;

    // Clear has priority over increment; increment stops at the top value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            countQ <= 32'd0;
        end else if (clr) begin
            countQ <= 32'd0;
        end else if (inc && (countQ != COUNT_MAX)) begin
            countQ <= countQ + 32'd1;
        end
    end

    assign count = countQ;

endmodule

// File: rtl/debug_step_controller.sv
// rtl/debug_step_controller.sv - run/step/restart sequencer driving pipeline enable and clear
module debug_step_controller
    import debug_step_controller_pkg::*;
#(
    parameter int RESET_CYCLES = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    debug_step_controller_if.slave       dbg
);

    localparam logic [3:0] FLUSH_LOAD = 4'(RESET_CYCLES - 1);

    state_t     stateQ;
    state_t     stateD;
    logic [3:0] flushCnt;
    logic       enable;
    logic       clear;
    logic       ready;
    logic       done;
    logic       accept;
    logic       enterFlush;

    // State register; every output below is decoded from it alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ <= ST_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Moore output decode followed by next-state selection.
    always_comb begin
        stateD = stateQ;
        enable = 1'b0;
        clear  = 1'b0;
        ready  = 1'b0;
        done   = 1'b0;
        case (stateQ)
            ST_IDLE:  ready = 1'b1;
            ST_RUN:   begin enable = 1'b1; ready = 1'b1; end
            ST_STEP:  enable = 1'b1;
            ST_FLUSH: clear = 1'b1;
            ST_DONE:  begin ready = 1'b1; done = 1'b1; end
            default:  ;
        endcase

        accept = dbg.cmdValid && ready;

        case (stateQ)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_t'(dbg.cmd))
                        CMD_RUN:     stateD = ST_RUN;
                        CMD_STEP:    stateD = ST_STEP;
                        CMD_RESTART: stateD = ST_FLUSH;
                        default:     stateD = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                // End of program outranks any command presented the same cycle.
                if (dbg.eopIn) begin
                    stateD = ST_DONE;
                end else if (accept) begin
                    case (cmd_t'(dbg.cmd))
                        CMD_HALT:    stateD = ST_IDLE;
                        CMD_RESTART: stateD = ST_FLUSH;
                        default:     stateD = ST_RUN;
                    endcase
                end
            end
            ST_STEP:  stateD = dbg.eopIn ? ST_DONE : ST_IDLE;
            ST_FLUSH: begin
                if (flushCnt == 4'd0) begin
                    stateD = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (accept && (cmd_t'(dbg.cmd) == CMD_RESTART)) begin
                    stateD = ST_FLUSH;
                end
            end
            default: stateD = ST_IDLE;
        endcase
    end

    assign enterFlush = (stateD == ST_FLUSH) && (stateQ != ST_FLUSH);

    // Flush length counter: loaded on entry, counts down to zero while flushing.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flushCnt <= 4'd0;
        end else if (enterFlush) begin
            flushCnt <= FLUSH_LOAD;
        end else if ((stateQ == ST_FLUSH) && (flushCnt != 4'd0)) begin
            flushCnt <= flushCnt - 4'd1;
        end
    end

    // Zeroed at the edge entering flush so the count already reads 0 in the first flush cycle.
    sat_counter32 uCounter (
        .clock (clock),
        .reset (reset),
        .inc   (enable),
        .clr   (enterFlush || (stateQ == ST_FLUSH)),
        .count (dbg.cycleCount)
    );

    assign dbg.cmdReady    = ready;
    assign dbg.debugEnable = enable;
    assign dbg.debugReset  = clear;
    assign dbg.halted      = done;
    assign dbg.state       = stateQ;

endmodule

// File: tb/tb_debug_step_controller.sv
// tb/tb_debug_step_controller.sv - directed bench with a cycle model of the step controller
module tb_debug_step_controller;
    import debug_step_controller_pkg::*;

    localparam int RC = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic checkOn = 1'b0;
    int   total = 0;
    int   bad = 0;

    debug_step_controller_if dif();

    debug_step_controller #(.RESET_CYCLES(RC)) dut (
        .clock (clock),
        .reset (reset),
        .dbg   (dif.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one mode, a flush progress count and the enabled-cycle tally.
    state_t      mMode = ST_IDLE;
    logic [31:0] mCnt = 32'd0;
    int          mFlush = 0;
    int          mPreSeen = 0;
    int          preTick = 0;
    logic [31:0] preVal = 32'd0;

    always @(posedge clock or negedge reset) begin : model
        logic [31:0] base;
        logic        take;
        longint      bumped;
        if (!reset) begin
            mMode    <= ST_IDLE;
            mCnt     <= 32'd0;
            mFlush   <= 0;
            mPreSeen <= preTick;
        end else begin
            base = (preTick != mPreSeen) ? preVal : mCnt;
            mPreSeen <= preTick;
            take = dif.cmdValid && (mMode == ST_IDLE || mMode == ST_RUN || mMode == ST_DONE);
            bumped = longint'(base) + 1;
            if (bumped > 64'hFFFF_FFFF) bumped = 64'hFFFF_FFFF;
            if (mMode == ST_RUN || mMode == ST_STEP) mCnt <= bumped[31:0];
            else mCnt <= base;
            case (mMode)
                ST_IDLE: if (take) begin
                    if (dif.cmd == CMD_RUN) mMode <= ST_RUN;
                    else if (dif.cmd == CMD_STEP) mMode <= ST_STEP;
                    else if (dif.cmd == CMD_RESTART) begin mMode <= ST_FLUSH; mFlush <= 0; mCnt <= 32'd0; end
                end
                ST_RUN: begin
                    if (dif.eopIn) mMode <= ST_DONE;
                    else if (take && dif.cmd == CMD_HALT) mMode <= ST_IDLE;
                    else if (take && dif.cmd == CMD_RESTART) begin mMode <= ST_FLUSH; mFlush <= 0; mCnt <= 32'd0; end
                end
                ST_STEP: mMode <= dif.eopIn ? ST_DONE : ST_IDLE;
                ST_FLUSH: begin
                    mCnt <= 32'd0;
                    mFlush <= mFlush + 1;
                    if (mFlush + 1 >= RC) mMode <= ST_IDLE;
                end
                ST_DONE: if (take && dif.cmd == CMD_RESTART) begin mMode <= ST_FLUSH; mFlush <= 0; mCnt <= 32'd0; end
                default: mMode <= ST_IDLE;
            endcase
        end
    end

    // Every cycle, compare all outputs with what the model's mode implies.
    always @(negedge clock) begin
        if (checkOn) begin
            check("state", 32'(dif.state), 32'(mMode));
            check("debugEnable", 32'(dif.debugEnable), 32'(mMode == ST_RUN || mMode == ST_STEP));
            check("debugReset", 32'(dif.debugReset), 32'(mMode == ST_FLUSH));
            check("halted", 32'(dif.halted), 32'(mMode == ST_DONE));
            check("cmdReady", 32'(dif.cmdReady), 32'(mMode == ST_IDLE || mMode == ST_RUN || mMode == ST_DONE));
            check("cycleCount", dif.cycleCount, (preTick != mPreSeen) ? preVal : mCnt);
        end
    end

    task automatic sendCmd(input cmd_t c);
        int n;
        n = 0;
        @(negedge clock);
        #1;
        dif.cmdValid = 1'b1;
        dif.cmd = c;
        while (!dif.cmdReady && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("cmdAccepted", 32'(dif.cmdReady), 32'd1);
        @(posedge clock);
        #1;
        dif.cmdValid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (dif.state != 3'(ST_IDLE) && n < 30) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("reachIdle", 32'(dif.state), 32'(ST_IDLE));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int pulses;
        dif.cmdValid = 1'b0;
        dif.cmd = CMD_HALT;
        dif.eopIn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        checkOn = 1'b1;
        check("rstState", 32'(dif.state), 32'd0);
        check("rstReady", 32'(dif.cmdReady), 32'd1);
        check("rstEnable", 32'(dif.debugEnable), 32'd0);
        check("rstClear", 32'(dif.debugReset), 32'd0);
        check("rstHalted", 32'(dif.halted), 32'd0);
        check("rstCount", dif.cycleCount, 32'd0);
        reset = 1'b1;

        // eopIn has no effect while idle
        dif.eopIn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        dif.eopIn = 1'b0;
        check("eopIdleState", 32'(dif.state), 32'd0);

        // RUN for 10 enabled cycles, eop during the 11th
        sendCmd(CMD_RUN);
        repeat (10) @(posedge clock);
        #1;
        dif.eopIn = 1'b1;
        @(posedge clock);
        #1;
        dif.eopIn = 1'b0;
        check("runDoneState", 32'(dif.state), 32'd4);
        check("runDoneHalted", 32'(dif.halted), 32'd1);
        check("runDoneCount", dif.cycleCount, 32'd11);

        // RUN in DONE is dropped
        sendCmd(CMD_RUN);
        check("doneDropsRun", 32'(dif.state), 32'd4);

        // RESTART from DONE: two flush cycles
        sendCmd(CMD_RESTART);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (dif.debugReset) pulses++;
        end
        check("flushPulses", 32'(pulses), 32'd2);
        check("restartState", 32'(dif.state), 32'd0);
        check("restartCount", dif.cycleCount, 32'd0);
        check("restartHalted", 32'(dif.halted), 32'd0);

        // three single steps
        for (int i = 0; i < 3; i++) begin
            sendCmd(CMD_STEP);
            @(negedge clock);
            check("stepReady", 32'(dif.cmdReady), 32'd0);
            check("stepEnable", 32'(dif.debugEnable), 32'd1);
        end
        @(posedge clock);
        #1;
        check("stepCount", dif.cycleCount, 32'd3);
        check("stepState", 32'(dif.state), 32'd0);

        // HALT and eop together in RUN: eop wins
        sendCmd(CMD_RUN);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        dif.cmdValid = 1'b1;
        dif.cmd = CMD_HALT;
        dif.eopIn = 1'b1;
        @(posedge clock);
        #1;
        dif.cmdValid = 1'b0;
        dif.eopIn = 1'b0;
        check("haltEopState", 32'(dif.state), 32'd4);
        check("haltEopHalted", 32'(dif.halted), 32'd1);

        // HALT alone freezes the count
        sendCmd(CMD_RESTART);
        waitIdle();
        sendCmd(CMD_RUN);
        repeat (4) @(posedge clock);
        sendCmd(CMD_HALT);
        repeat (5) @(posedge clock);
        #1;
        check("haltState", 32'(dif.state), 32'd0);
        check("haltFrozenCount", dif.cycleCount, 32'd5);

        // reset mid-RUN
        sendCmd(CMD_RUN);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("midRunEnable", 32'(dif.debugEnable), 32'd0);
        check("midRunState", 32'(dif.state), 32'd0);
        check("midRunCount", dif.cycleCount, 32'd0);
        @(negedge clock);
        #1;
        reset = 1'b1;

        // reset in the first of two flush cycles
        sendCmd(CMD_RESTART);
        check("flushActive", 32'(dif.debugReset), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("midFlushClear", 32'(dif.debugReset), 32'd0);
        check("midFlushState", 32'(dif.state), 32'd0);
        @(negedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("postFlushState", 32'(dif.state), 32'd0);
        check("postFlushClear", 32'(dif.debugReset), 32'd0);
        check("postFlushCount", dif.cycleCount, 32'd0);
        repeat (3) @(posedge clock);

        // saturation: preload near the top and run five cycles
        @(negedge clock);
        #1;
        force dut.uCounter.countQ = 32'hFFFF_FFFE;
        #1;
        release dut.uCounter.countQ;
        preVal = 32'hFFFF_FFFE;
        preTick++;
        check("preload", dif.cycleCount, 32'hFFFF_FFFE);
        sendCmd(CMD_RUN);
        repeat (4) @(posedge clock);
        sendCmd(CMD_HALT);
        @(posedge clock);
        #1;
        check("satCount", dif.cycleCount, 32'hFFFF_FFFF);
        check("satState", 32'(dif.state), 32'd0);

        repeat (2) @(posedge clock);
        checkOn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
